tsc_fetch_decode_ctrl: RTL and testbench
========================================

Name: tsc_fetch_decode_ctrl

Overview:
- Instruction fetch/decode controller sitting directly upstream of the 16-bit ALU in the single-cycle TSC CPU.
- Fetches one instruction per cycle-group from memory with a readM/inputReady handshake and latches it in an instruction register.
- Decodes the instruction into the ALU op code, operand-source select, immediate and register-file controls.
- Maintains the PC and a retired-instruction counter; halts on an unsupported opcode.

Parameters:
- WORD_SIZE, 16, datapath/instruction/address width.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- readM  out  1  memory read request
- address  out  16  fetch address (= PC)
- data  in  16  instruction from memory; valid when inputReady=1
- inputReady  in  1  memory data valid
- alu_op  out  4  ALU op: 0000 add, 0001 LHI, 0010 WWD
- alu_cin  out  1  ALU carry-in (always 0 for supported ops)
- alu_src_imm  out  1  1 = ALU B operand from imm_ext, 0 = from rt register
- imm_ext  out  16  extended immediate
- rs_addr  out  2  source register A, IR[11:10]
- rt_addr  out  2  source register B, IR[9:8]
- rd_addr  out  2  register-file write destination
- reg_write  out  1  register-file write strobe, one cycle
- wwd_valid  out  1  output_port update strobe, one cycle
- num_inst  out  16  retired-instruction count
- halted  out  1  sticky illegal-opcode halt flag

Behaviour:
- States: IDLE, FETCH, EXEC, HALT. An asynchronous reset_n low forces IDLE at any time, including mid-FETCH: PC=RESET_PC, IR=0, num_inst=0, halted=0, readM=0, reg_write=0, wwd_valid=0. All decode outputs are 0 at reset.
- IDLE -> FETCH on the first clk edge after reset_n is high.
- FETCH:
  - readM=1 and address=PC for every cycle in this state.
  - On a clk edge with inputReady=1: IR<=data, go to EXEC.
  - Otherwise stay in FETCH. Minimum fetch is 1 cycle; there is no timeout.
- EXEC (exactly 1 cycle):
  - readM=0.
  - Decode outputs are valid.
  - reg_write/wwd_valid pulse high for this cycle only.
  - At the closing edge: PC<=PC+1 (mod 2^16), num_inst<=num_inst+1 (wraps 0xFFFF->0), go to FETCH.
- Decode, using opcode=IR[15:12] and func=IR[5:0]:
  - ADD (op 15, func 0): alu_op=0000, alu_src_imm=0, rd_addr=IR[7:6], reg_write=1.
  - ADI (op 4): alu_op=0000, alu_src_imm=1, imm_ext=sign-extend IR[7:0], rd_addr=IR[9:8], reg_write=1.
  - LHI (op 6): alu_op=0001, alu_src_imm=1, imm_ext={8'h00,IR[7:0]}, rd_addr=IR[9:8], reg_write=1.
  - WWD (op 15, func 28): alu_op=0010, wwd_valid=1, reg_write=0.
- Decode outputs for an unsupported instruction are all 0.
- Any other opcode/func in EXEC:
  - go to HALT; halted=1.
  - No PC or num_inst update, no strobes.
- HALT: readM=0, all strobes 0, stays there until reset_n is asserted.
- Decode outputs are combinational from IR and held stable outside EXEC. Strobes are gated to EXEC only.
- alu_cin is always 0.

Optional Feature:
- Macro: TSC_JMP_EN.
- When defined: JMP (op 9) is legal. In EXEC, PC<={PC[15:12], IR[11:0]} replaces PC+1. num_inst increments. No reg_write or wwd_valid. alu_op=0000.
- When undefined: op 9 is illegal and the block enters HALT.

Test Plan:
- Reset, then fetch with inputReady delayed 2 cycles, data=0x41FF (ADI rt=1, imm=-1) -> readM=1 with address=0x0000 for 3 cycles. Then EXEC: alu_op=0000, alu_src_imm=1, imm_ext=0xFFFF, rd_addr=1, reg_write pulse of 1 cycle. Then PC=1, num_inst=1.
- data=0xF6C0 (ADD rs=1, rt=2, rd=3) -> rs_addr=1, rt_addr=2, rd_addr=3, alu_src_imm=0, reg_write=1.
- data=0x625A (LHI rt=2, imm=0x5A) -> alu_op=0001, imm_ext=0x005A, rd_addr=2, reg_write=1.
- data=0xF41C (WWD rs=1) -> alu_op=0010, rs_addr=1, wwd_valid=1, reg_write=0, num_inst increments.
- data=0x0000 -> halted=1, readM stays 0 for 20 cycles, PC and num_inst unchanged. Separately, reset_n pulled low mid-FETCH -> readM=0 and PC=0 immediately, without waiting for clk.
- data=0x9123 with TSC_JMP_EN -> next fetch address=0x0123 and num_inst increments. Without the macro -> halted=1.

Source files
------------

// File: rtl/tsc_fetch_decode_ctrl.sv
// Fetch/decode controller feeding the TSC 16-bit ALU: fetch handshake, IR, decode, PC, retire count.
// Optional: define TSC_JMP_EN to make JMP (opcode 9) legal instead of halting on it.
module tsc_fetch_decode_ctrl #(
  parameter int unsigned            WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0]   RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 readM,
  output logic [WORD_SIZE-1:0] address,
  input  logic [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  output logic [3:0]           alu_op,
  output logic                 alu_cin,
  output logic                 alu_src_imm,
  output logic [WORD_SIZE-1:0] imm_ext,
  output logic [1:0]           rs_addr,
  output logic [1:0]           rt_addr,
  output logic [1:0]           rd_addr,
  output logic                 reg_write,
  output logic                 wwd_valid,
  output logic [WORD_SIZE-1:0] num_inst,
  output logic                 halted
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StExec  = 2'd2;
  localparam logic [1:0] StHalt  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] ir_q, ir_d;
  logic [WORD_SIZE-1:0] num_inst_q, num_inst_d;

  logic [3:0] opcode;
  logic [5:0] func;
  logic       dec_legal;
  logic       dec_jmp;
  logic       dec_reg_write;
  logic       dec_wwd;

  assign opcode = ir_q[15:12];
  assign func   = ir_q[5:0];

  // Decode is purely a function of IR, so it stays stable while the next fetch is pending.
  always_comb begin
    dec_legal     = 1'b0;
    dec_jmp       = 1'b0;
    dec_reg_write = 1'b0;
    dec_wwd       = 1'b0;
    alu_op        = 4'b0000;
    alu_src_imm   = 1'b0;
    imm_ext       = '0;
    rd_addr       = 2'b00;
    rs_addr       = 2'b00;
    rt_addr       = 2'b00;
    case (opcode)
      4'd4: begin
        dec_legal     = 1'b1;
        alu_src_imm   = 1'b1;
        imm_ext       = {{(WORD_SIZE-8){ir_q[7]}}, ir_q[7:0]};
        rd_addr       = ir_q[9:8];
        dec_reg_write = 1'b1;
      end
      4'd6: begin
        dec_legal     = 1'b1;
        alu_op        = 4'b0001;
        alu_src_imm   = 1'b1;
        imm_ext       = {{(WORD_SIZE-8){1'b0}}, ir_q[7:0]};
        rd_addr       = ir_q[9:8];
        dec_reg_write = 1'b1;
      end
      4'd15: begin
        if (func == 6'd0) begin
          dec_legal     = 1'b1;
          rd_addr       = ir_q[7:6];
          dec_reg_write = 1'b1;
        end else if (func == 6'd28) begin
          dec_legal = 1'b1;
          alu_op    = 4'b0010;
          dec_wwd   = 1'b1;
        end
      end
`ifdef TSC_JMP_EN
      4'd9: begin
        dec_legal = 1'b1;
        dec_jmp   = 1'b1;
      end
`else
`endif
      default: ;
    endcase
    if (dec_legal) begin
      rs_addr = ir_q[11:10];
      rt_addr = ir_q[9:8];
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    num_inst_d = num_inst_q;
    case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (inputReady) begin
          ir_d    = data;
          state_d = StExec;
        end
      end
      StExec: begin
        if (dec_legal) begin
          pc_d       = dec_jmp ? {pc_q[WORD_SIZE-1:12], ir_q[11:0]} : pc_q + 1'b1;
          num_inst_d = num_inst_q + 1'b1;
          state_d    = StFetch;
        end else begin
          state_d = StHalt;
        end
      end
      default: state_d = StHalt;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      num_inst_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      num_inst_q <= num_inst_d;
    end
  end

  assign readM     = (state_q == StFetch);
  assign address   = pc_q;
  assign alu_cin   = 1'b0;
  assign reg_write = (state_q == StExec) && dec_reg_write;
  assign wwd_valid = (state_q == StExec) && dec_wwd;
  assign num_inst  = num_inst_q;
  assign halted    = (state_q == StHalt);

endmodule

// File: tb/tb_tsc_fetch_decode_ctrl.sv
// Randomized self-checking bench for tsc_fetch_decode_ctrl against an instruction-level model.
module tb_tsc_fetch_decode_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        readM;
  logic [15:0] address;
  logic [15:0] data;
  logic        inputReady;
  logic [3:0]  alu_op;
  logic        alu_cin;
  logic        alu_src_imm;
  logic [15:0] imm_ext;
  logic [1:0]  rs_addr, rt_addr, rd_addr;
  logic        reg_write, wwd_valid;
  logic [15:0] num_inst;
  logic        halted;

  always #5 clk = ~clk;

  tsc_fetch_decode_ctrl #(.WORD_SIZE(16), .RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .readM      (readM),
    .address    (address),
    .data       (data),
    .inputReady (inputReady),
    .alu_op     (alu_op),
    .alu_cin    (alu_cin),
    .alu_src_imm(alu_src_imm),
    .imm_ext    (imm_ext),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rd_addr    (rd_addr),
    .reg_write  (reg_write),
    .wwd_valid  (wwd_valid),
    .num_inst   (num_inst),
    .halted     (halted)
  );

  typedef struct {
    bit legal;
    bit jmp;
    int op;
    int src;
    int imm;
    int rs;
    int rt;
    int rd;
    int wr;
    int wwd;
  } dec_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Architectural model state
  int m_pc;
  int m_num;
  int m_ir;
  bit m_halted;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic dec_t ref_decode(input int ir);
    dec_t d;
    int opc, fn, low8;
    opc  = ir / 4096;
    fn   = ir % 64;
    low8 = ir % 256;
    d = '{default: 0};
    if (opc == 4) begin
      d.legal = 1; d.src = 1; d.wr = 1;
      d.imm = (low8 >= 128) ? low8 + 65280 : low8;
      d.rd  = (ir / 256) % 4;
    end else if (opc == 6) begin
      d.legal = 1; d.src = 1; d.wr = 1; d.op = 1;
      d.imm = low8;
      d.rd  = (ir / 256) % 4;
    end else if (opc == 15 && fn == 0) begin
      d.legal = 1; d.wr = 1;
      d.rd  = (ir / 64) % 4;
    end else if (opc == 15 && fn == 28) begin
      d.legal = 1; d.op = 2; d.wwd = 1;
    end
`ifdef TSC_JMP_EN
    else if (opc == 9) begin
      d.legal = 1; d.jmp = 1;
    end
`endif
    if (d.legal) begin
      d.rs = (ir / 1024) % 4;
      d.rt = (ir / 256) % 4;
    end
    return d;
  endfunction

  task automatic check_decode(input string pfx, input int ir);
    dec_t d;
    d = ref_decode(ir);
    check_eq({pfx, ".alu_op"}, alu_op, d.op);
    check_eq({pfx, ".alu_src_imm"}, alu_src_imm, d.src);
    check_eq({pfx, ".imm_ext"}, imm_ext, d.imm);
    check_eq({pfx, ".rs_addr"}, rs_addr, d.rs);
    check_eq({pfx, ".rt_addr"}, rt_addr, d.rt);
    check_eq({pfx, ".rd_addr"}, rd_addr, d.rd);
    check_eq({pfx, ".alu_cin"}, alu_cin, 0);
  endtask

  // Assert reset asynchronously, release it, and step through IDLE into FETCH.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    m_pc = 0; m_num = 0; m_ir = 0; m_halted = 0;
    check_eq("rst.readM", readM, 0);
    check_eq("rst.address", address, 0);
    check_eq("rst.num_inst", num_inst, 0);
    check_eq("rst.halted", halted, 0);
    check_eq("rst.reg_write", reg_write, 0);
    check_eq("rst.wwd_valid", wwd_valid, 0);
    check_decode("rst", 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    check_eq("idle.readM", readM, 0);
    @(posedge clk); #1;
  endtask

  // Entered 1 time unit after an edge with the DUT in FETCH.
  task automatic run_inst(input logic [15:0] instr, input int delay);
    dec_t d;
    for (int i = 0; i < delay; i++) begin
      inputReady = 1'b0;
      data = 16'($urandom);
      check_eq("fetch.readM", readM, 1);
      check_eq("fetch.address", address, m_pc);
      check_eq("fetch.reg_write", reg_write, 0);
      check_eq("fetch.wwd_valid", wwd_valid, 0);
      check_decode("hold", m_ir);
      @(posedge clk); #1;
    end
    data = instr;
    inputReady = 1'b1;
    check_eq("fetch.readM", readM, 1);
    check_eq("fetch.address", address, m_pc);
    @(posedge clk); #1;
    inputReady = 1'b0;
    data = 16'($urandom);
    m_ir = int'(instr);
    d = ref_decode(m_ir);
    check_eq("exec.readM", readM, 0);
    check_eq("exec.reg_write", reg_write, d.wr);
    check_eq("exec.wwd_valid", wwd_valid, d.wwd);
    check_eq("exec.halted", halted, 0);
    check_decode("exec", m_ir);
    @(posedge clk); #1;
    if (d.legal) begin
      m_num = (m_num + 1) % 65536;
      m_pc  = d.jmp ? (m_pc / 4096) * 4096 + (m_ir % 4096) : (m_pc + 1) % 65536;
      check_eq("next.readM", readM, 1);
    end else begin
      m_halted = 1;
      check_eq("next.readM", readM, 0);
    end
    check_eq("next.halted", halted, m_halted);
    check_eq("next.address", address, m_pc);
    check_eq("next.num_inst", num_inst, m_num);
    check_eq("next.reg_write", reg_write, 0);
    check_eq("next.wwd_valid", wwd_valid, 0);
  endtask

  function automatic logic [15:0] rand_legal();
    int kind;
    logic [15:0] r;
`ifdef TSC_JMP_EN
    kind = $urandom_range(0, 4);
`else
    kind = $urandom_range(0, 3);
`endif
    r = 16'($urandom);
    case (kind)
      0: return {4'h4, r[11:0]};
      1: return {4'h6, r[11:0]};
      2: return {4'hF, r[11:6], 6'd0};
      3: return {4'hF, r[11:6], 6'd28};
      default: return {4'h9, r[11:0]};
    endcase
  endfunction

  task automatic check_halt_hold(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      inputReady = 1'($urandom);
      data = 16'($urandom);
      @(posedge clk); #1;
      check_eq("halt.readM", readM, 0);
      check_eq("halt.halted", halted, 1);
      check_eq("halt.address", address, m_pc);
      check_eq("halt.num_inst", num_inst, m_num);
      check_eq("halt.reg_write", reg_write, 0);
      check_eq("halt.wwd_valid", wwd_valid, 0);
    end
    inputReady = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    inputReady = 1'b0;
    data       = 16'h0000;
    @(posedge clk); #1;
    do_reset();

    run_inst(16'h41FF, 2);
    run_inst(16'hF6C0, 0);
    run_inst(16'h625A, 1);
    run_inst(16'hF41C, 0);
    check_eq("plan.num_inst", num_inst, 4);

    for (int n = 0; n < 60; n++) run_inst(rand_legal(), $urandom_range(0, 3));

    // Reset while a fetch is pending must take effect without a clock edge.
    inputReady = 1'b0;
    @(posedge clk); #1;
    check_eq("midfetch.readM", readM, 1);
    do_reset();

    run_inst(16'h41FF, 0);
    run_inst(16'h9123, 1);
    if (m_halted) begin
      check_halt_hold(3);
      do_reset();
    end else begin
      check_eq("jmp.address", address, 16'h0123);
    end

    for (int n = 0; n < 20; n++) run_inst(rand_legal(), $urandom_range(0, 2));

    run_inst(16'h0000, 0);
    check_halt_hold(20);
    do_reset();
    run_inst(16'hF6C0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
